// File: rtl/servo_position_ctrl.sv
// servo_position_ctrl: push-button front end for the servo PWM generator.
// Synchronises and debounces BC/BL/BR, then runs a centre/left/right FSM.
// While moving, the FSM ramps a 20-bit pulse-width command between POS_MIN
// and POS_MAX.
// Optional feature: define SERVO_SWEEP_EN to add a SWEEP input and an
// autonomous sweep state that bounces between the two limits.
module servo_position_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          STEP_CYCLES     = 2_000_000,
    parameter logic [19:0] POS_MIN         = 20'h0AFC8,
    parameter logic [19:0] POS_MAX         = 20'h19A28,
    parameter logic [19:0] POS_CENTER      = 20'h124F8,
    parameter logic [19:0] DELTA           = 20'h001F4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        BC,
    input  logic        BL,
    input  logic        BR,
`ifdef SERVO_SWEEP_EN
    input  logic        SWEEP,
`endif
    output logic [19:0] SELECT,
    output logic        UPD,
    output logic [2:0]  LEDS,
    output logic        AT_MIN,
    output logic        AT_MAX
);

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TCW-1:0] ST_LAST = TCW'(STEP_CYCLES - 1);

    // Button bit order: [0]=R, [1]=L, [2]=C, [3]=SWEEP (when present)
`ifdef SERVO_SWEEP_EN
    localparam int NB = 4;
    logic [NB-1:0] w_raw;
    assign w_raw = {SWEEP, BC, BL, BR};
`else
    localparam int NB = 3;
    logic [NB-1:0] w_raw;
    assign w_raw = {BC, BL, BR};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CENTER,
        S_MOVE_L,
        S_MOVE_R
`ifdef SERVO_SWEEP_EN
        , S_SWEEP
`endif
    } state_t;

    logic [NB-1:0]          r_sync1, r_sync2, r_db;
    logic [NB-1:0][DCW-1:0] r_dbcnt;
    state_t                 r_state, w_state_nxt;
    logic [19:0]            r_sel, w_sel_nxt;
    logic [TCW-1:0]         r_tmr, w_tmr_nxt;
    logic                   r_upd, r_at_min, r_at_max;
    logic [2:0]             r_leds, w_leds_nxt;
    logic                   w_step, w_step_left;
    logic                   w_req_c, w_req_l, w_req_r;
    logic [19:0]            w_room_lo, w_room_hi;

    // 2-FF synchroniser plus per-button debounce: the count runs only while
    // the sample disagrees with the accepted level, so any bounce back clears it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_dbcnt <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DB_LAST) begin
                    r_db[i]    <= r_sync2[i];
                    r_dbcnt[i] <= '0;
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + DCW'(1);
                end
            end
        end
    end

    // Fixed priority C > L > R on debounced levels
    assign w_req_c = r_db[2];
    assign w_req_l = r_db[1] & ~r_db[2];
    assign w_req_r = r_db[0] & ~r_db[1] & ~r_db[2];

    // Headroom toward each limit; comparing differences avoids wrap-around
    assign w_room_lo = r_sel - POS_MIN;
    assign w_room_hi = POS_MAX - r_sel;

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: decided purely by the current requests, from any state
    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_req_c)      w_state_nxt = S_CENTER;
        else if (w_req_l) w_state_nxt = S_MOVE_L;
        else if (w_req_r) w_state_nxt = S_MOVE_R;
`ifdef SERVO_SWEEP_EN
        else if (r_db[3]) w_state_nxt = S_SWEEP;
`endif
    end

`ifdef SERVO_SWEEP_EN
    logic r_dir, w_dir_nxt, w_dir_cur, w_sweep_right;
    // Sweep always starts rightward on entry; bounce off whichever limit is hit
    always_comb begin
        w_dir_cur     = (r_state == S_SWEEP) ? r_dir : 1'b1;
        w_sweep_right = w_dir_cur;
        if (w_dir_cur && r_sel == POS_MAX)       w_sweep_right = 1'b0;
        else if (!w_dir_cur && r_sel == POS_MIN) w_sweep_right = 1'b1;
    end
`endif

    // Output next-values: step timing, ramp arithmetic, LED pattern
    always_comb begin
        w_sel_nxt   = r_sel;
        w_tmr_nxt   = '0;
        w_step      = 1'b0;
        w_step_left = 1'b0;
        w_leds_nxt  = 3'b000;
`ifdef SERVO_SWEEP_EN
        w_dir_nxt   = r_dir;
`endif
        case (w_state_nxt)
            S_CENTER: begin
                w_sel_nxt  = POS_CENTER;
                w_leds_nxt = 3'b010;
            end
            S_MOVE_L, S_MOVE_R: begin
                w_step_left = (w_state_nxt == S_MOVE_L);
                w_leds_nxt  = (w_state_nxt == S_MOVE_L) ? 3'b100 : 3'b001;
                if (r_state != w_state_nxt || r_tmr == ST_LAST) w_step = 1'b1;
                else w_tmr_nxt = r_tmr + TCW'(1);
            end
`ifdef SERVO_SWEEP_EN
            S_SWEEP: begin
                w_step_left = ~w_sweep_right;
                w_leds_nxt  = 3'b101;
                if (r_state != S_SWEEP || r_tmr == ST_LAST) begin
                    w_step    = 1'b1;
                    w_dir_nxt = w_sweep_right;
                end else begin
                    w_tmr_nxt = r_tmr + TCW'(1);
                end
            end
`endif
            default: ;
        endcase
        if (w_step) begin
            if (w_step_left) w_sel_nxt = (w_room_lo >= DELTA) ? r_sel - DELTA : POS_MIN;
            else             w_sel_nxt = (w_room_hi >= DELTA) ? r_sel + DELTA : POS_MAX;
        end
    end

    // Registered outputs; UPD flags a real change so saturated steps stay silent
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sel    <= POS_CENTER;
            r_tmr    <= '0;
            r_upd    <= 1'b0;
            r_at_min <= 1'b0;
            r_at_max <= 1'b0;
            r_leds   <= 3'b000;
        end else begin
            r_sel    <= w_sel_nxt;
            r_tmr    <= w_tmr_nxt;
            r_upd    <= (w_sel_nxt != r_sel);
            r_at_min <= (w_sel_nxt == POS_MIN);
            r_at_max <= (w_sel_nxt == POS_MAX);
            r_leds   <= w_leds_nxt;
        end
    end

`ifdef SERVO_SWEEP_EN
    // Sweep direction memory, rightward out of reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_dir <= 1'b1;
        else        r_dir <= w_dir_nxt;
    end
`endif

    assign SELECT = r_sel;
    assign UPD    = r_upd;
    assign LEDS   = r_leds;
    assign AT_MIN = r_at_min;
    assign AT_MAX = r_at_max;

endmodule

// File: tb/tb_servo_position_ctrl.sv
// Scoreboard bench for servo_position_ctrl (DEBOUNCE_CYCLES=4, STEP_CYCLES=10).
// Stimulus pushes the expected SELECT value and the cycle it must appear on;
// the monitor pops one entry on every UPD strobe.
module tb_servo_position_ctrl;

    localparam logic [19:0] P_MIN = 20'h0AFC8;
    localparam logic [19:0] P_MAX = 20'h19A28;
    localparam logic [19:0] P_CEN = 20'h124F8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        BC = 1'b0, BL = 1'b0, BR = 1'b0;
    logic [19:0] SELECT;
    logic        UPD;
    logic [2:0]  LEDS;
    logic        AT_MIN, AT_MAX;

    servo_position_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(10)) dut (
        .CLK(CLK), .RST_N(RST_N), .BC(BC), .BL(BL), .BR(BR),
        .SELECT(SELECT), .UPD(UPD), .LEDS(LEDS), .AT_MIN(AT_MIN), .AT_MAX(AT_MAX)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] sel;
        int          cyc;
    } exp_t;
    exp_t q[$];
    exp_t m_e;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input logic [19:0] v, input int c);
        exp_t e;
        e.sel = v;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: every UPD strobe must match the next scoreboard entry
    always @(negedge CLK) begin
        if (RST_N && UPD) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL upd_unexpected: SELECT=%0h at cycle %0d, none expected", SELECT, cyc);
            end else begin
                m_e = q.pop_front();
                chk("upd_sel", SELECT, m_e.sel);
                chk("upd_cyc", cyc, m_e.cyc);
                chk("upd_at_min", AT_MIN, m_e.sel == P_MIN);
                chk("upd_at_max", AT_MAX, m_e.sel == P_MAX);
            end
        end
    end

    int c0;

    initial begin
        // Reset state, checked before any clock edge
        #1 RST_N = 1'b0;
        #1;
        chk("rst_sel", SELECT, P_CEN);
        chk("rst_upd", UPD, 0);
        chk("rst_leds", LEDS, 3'b000);
        chk("rst_at_min", AT_MIN, 0);
        chk("rst_at_max", AT_MAX, 0);
        cycles(3);
        RST_N = 1'b1;

        // Idle with no buttons for 100 cycles
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            chk("idle_sel", SELECT, P_CEN);
            chk("idle_leds", LEDS, 3'b000);
        end

        // Left ramp from centre to POS_MIN: 60 steps, 10 cycles apart
        c0 = cyc;
        BL = 1'b1;
        for (int n = 1; n <= 60; n++) push(P_CEN - 20'(n * 500), c0 + 7 + 10 * (n - 1));
        cycles(7);
        chk("left_first", SELECT, 20'h12304);
        chk("left_leds", LEDS, 3'b100);
        cycles(590);
        chk("left_min_sel", SELECT, 20'h0AFC8);
        chk("left_at_min", AT_MIN, 1);
        cycles(40);
        chk("left_hold_sel", SELECT, 20'h0AFC8);
        chk("left_drain", q.size(), 0);
        BL = 1'b0;
        cycles(20);
        chk("left_rel_leds", LEDS, 3'b000);
        chk("left_rel_sel", SELECT, 20'h0AFC8);

        // Back to centre
        c0 = cyc;
        BC = 1'b1;
        push(P_CEN, c0 + 7);
        cycles(7);
        chk("ctr1_sel", SELECT, 20'h124F8);
        chk("ctr1_leds", LEDS, 3'b010);
        BC = 1'b0;
        cycles(20);
        chk("ctr1_rel_leds", LEDS, 3'b000);

        // Right ramp to POS_MAX, then saturate
        c0 = cyc;
        BR = 1'b1;
        for (int n = 1; n <= 60; n++) push(P_CEN + 20'(n * 500), c0 + 7 + 10 * (n - 1));
        cycles(597);
        chk("right_max_sel", SELECT, 20'h19A28);
        chk("right_at_max", AT_MAX, 1);
        chk("right_at_min", AT_MIN, 0);
        cycles(40);
        chk("right_hold_sel", SELECT, 20'h19A28);
        chk("right_drain", q.size(), 0);
        BR = 1'b0;
        cycles(20);

        // BL bounce: 2-cycle pulses never debounce, then stable high
        for (int i = 0; i < 10; i++) begin
            BL = (i % 2 == 0);
            cycles(2);
        end
        chk("bounce_hold", SELECT, 20'h19A28);
        c0 = cyc;
        BL = 1'b1;
        for (int n = 1; n <= 119; n++) push(P_MAX - 20'(n * 500), c0 + 7 + 10 * (n - 1));
        cycles(6);
        chk("bounce_no_step_yet", SELECT, 20'h19A28);
        cycles(1);
        chk("bounce_first", SELECT, 20'h19834);
        cycles(1180);
        chk("bounce_last", SELECT, 20'h0B1BC);
        BL = 1'b0;
        cycles(20);
        chk("bounce_drain", q.size(), 0);
        chk("bounce_rel_sel", SELECT, 20'h0B1BC);
        chk("bounce_rel_leds", LEDS, 3'b000);

        // Centre from 0B1BC, then BL added while BC held stays centre
        c0 = cyc;
        BC = 1'b1;
        push(P_CEN, c0 + 7);
        cycles(7);
        chk("ctr2_sel", SELECT, 20'h124F8);
        chk("ctr2_leds", LEDS, 3'b010);
        BL = 1'b1;
        cycles(20);
        chk("bc_bl_leds", LEDS, 3'b010);
        chk("bc_bl_sel", SELECT, 20'h124F8);
        c0 = cyc;
        BC = 1'b0;
        push(20'h12304, c0 + 7);
        cycles(7);
        chk("bc_rel_left_leds", LEDS, 3'b100);
        BL = 1'b0;
        cycles(20);
        chk("bc_rel_idle_leds", LEDS, 3'b000);

        // BL+BR together acts as left
        c0 = cyc;
        BL = 1'b1;
        BR = 1'b1;
        push(20'h12110, c0 + 7);
        cycles(7);
        chk("bl_br_leds", LEDS, 3'b100);
        chk("bl_br_sel", SELECT, 20'h12110);
        BL = 1'b0;
        BR = 1'b0;
        cycles(20);
        chk("bl_br_drain", q.size(), 0);

        // Asynchronous reset in the middle of a right ramp
        c0 = cyc;
        BR = 1'b1;
        push(20'h12304, c0 + 7);
        push(20'h124F8, c0 + 17);
        push(20'h126EC, c0 + 27);
        cycles(30);
        chk("mid_r_leds", LEDS, 3'b001);
        chk("mid_r_sel", SELECT, 20'h126EC);
        RST_N = 1'b0;
        #1;
        chk("async_rst_sel", SELECT, P_CEN);
        chk("async_rst_leds", LEDS, 3'b000);
        chk("async_rst_upd", UPD, 0);
        BR = 1'b0;
        cycles(3);
        RST_N = 1'b1;
        cycles(20);
        chk("post_rst_sel", SELECT, P_CEN);
        chk("post_rst_leds", LEDS, 3'b000);
        chk("final_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
